add8_serial: RTL and testbench

- Bit-serial 8-bit adder for the Chapter 4 ALU. It is the multi-cycle adding counterpart to the combinational subtractor.
- Processes one bit per clock, LSB first, with a single ripple-carry flip-flop.
- Uses a start/busy/done handshake so a sequencer or testbench can issue operations and collect sum, carry-out and signed-overflow flags.

---
 rtl/add8_serial_if.sv | 24 ++
 rtl/add8_serial.sv | 112 +++++++++++
 tb/tb_add8_serial.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/add8_serial_if.sv
// Handshake and data bundle for the bit-serial adder.
// master: the sequencer issuing operations; slave: the adder itself.
interface add8_serial_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             i_start;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_res;
  logic             o_cout;
  logic             o_ovf;

  modport master (
    output i_start, i_a, i_b,
    input  o_busy, o_done, o_res, o_cout, o_ovf
  );

  modport slave (
    input  i_start, i_a, i_b,
    output o_busy, o_done, o_res, o_cout, o_ovf
  );
endinterface

// File: rtl/add8_serial.sv
// Bit-serial adder: one bit per clock, LSB first, single carry flip-flop.
// start/busy/done handshake; result, carry-out and signed overflow are
// registered and held until the next completion.
module add8_serial #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input logic          clk,
  input logic          rst,
  add8_serial_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_sum;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_res;
  logic             r_cout;
  logic             r_ovf;

  logic             w_ready;
  logic             w_accept;
  logic             w_last;
  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_sum_cat;

  // Operands shift right each bit, so bit 0 is always the current bit; on
  // the last edge it therefore holds the operand MSBs needed for ovf.
  // The sum register is one bit narrower than the result: after WIDTH-1
  // shifts it holds bits [WIDTH-2:0] and the final bit completes it.
  always_comb begin
    w_ready   = (r_state == IDLE) || (r_state == DONE);
    w_accept  = w_ready && bus.i_start;
    w_last    = (r_state == RUN) && (r_cnt == CNT_W'(WIDTH - 1));
    w_s       = r_a[0] ^ r_b[0] ^ r_carry;
    w_c       = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
    w_sum_cat = {w_s, r_sum};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.i_start) w_next = RUN;
      RUN:     if (w_last)      w_next = DONE;
      DONE:    w_next = bus.i_start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: operand capture, bit processing, result update, flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_res   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_busy <= (w_next == RUN);
      r_done <= (w_next == DONE);
      if (w_accept) begin
        r_a     <= bus.i_a;
        r_b     <= bus.i_b;
        r_carry <= 1'b0;
        r_cnt   <= '0;
      end else if (r_state == RUN) begin
        r_a     <= r_a >> 1;
        r_b     <= r_b >> 1;
        r_sum   <= w_sum_cat[WIDTH-1:1];
        r_carry <= w_c;
        r_cnt   <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_res  <= w_sum_cat;
          r_cout <= w_c;
          r_ovf  <= (r_a[0] == r_b[0]) && (w_s != r_a[0]);
        end
      end
    end
  end

  assign bus.o_busy = r_busy;
  assign bus.o_done = r_done;
  assign bus.o_res  = r_res;
  assign bus.o_cout = r_cout;
  assign bus.o_ovf  = r_ovf;

endmodule

// File: tb/tb_add8_serial.sv
// Directed testbench for add8_serial: a vector table of hand-computed sums
// plus sequences for ignored start, back-to-back start and mid-op reset.
module tb_add8_serial;

  logic clk;
  logic rst;

  add8_serial_if #(.WIDTH(8)) bus ();

  add8_serial #(.WIDTH(8), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       cout;
    logic       ovf;
  } vec_t;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;
  logic [7:0]  prev_res = 8'd0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Issue one operation and follow it to completion.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic [7:0] er,
                        input logic ec, input logic eo, input string tag);
    int n;
    logic stable;
    bus.i_a     = ta;
    bus.i_b     = tb_;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    chk({tag, "_busy_rise"}, 32'(bus.o_busy), 32'd1);
    n = 0;
    stable = 1'b1;
    while (!bus.o_done && n < 20) begin
      if (bus.o_res !== prev_res || bus.o_busy !== 1'b1) stable = 1'b0;
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd8);
    chk({tag, "_hold_busy"}, 32'(stable), 32'd1);
    chk({tag, "_res"}, 32'(bus.o_res), 32'(er));
    chk({tag, "_cout"}, 32'(bus.o_cout), 32'(ec));
    chk({tag, "_ovf"}, 32'(bus.o_ovf), 32'(eo));
    chk({tag, "_busy_at_done"}, 32'(bus.o_busy), 32'd0);
    tick();
    chk({tag, "_done_pulse"}, 32'(bus.o_done), 32'd0);
    chk({tag, "_res_hold"}, 32'(bus.o_res), 32'(er));
    prev_res = er;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    int n;
    int dones;
    int cyc;

    vecs[0] = '{a: 8'd124,  b: 8'd1,    res: 8'd125,  cout: 1'b0, ovf: 1'b0};
    vecs[1] = '{a: 8'd124,  b: 8'd42,   res: 8'd166,  cout: 1'b0, ovf: 1'b1};
    vecs[2] = '{a: 8'd200,  b: 8'd100,  res: 8'd44,   cout: 1'b1, ovf: 1'b0};
    vecs[3] = '{a: 8'hFF,   b: 8'h01,   res: 8'h00,   cout: 1'b1, ovf: 1'b0};
    vecs[4] = '{a: 8'h80,   b: 8'h80,   res: 8'h00,   cout: 1'b1, ovf: 1'b1};
    vecs[5] = '{a: 8'h7F,   b: 8'h80,   res: 8'hFF,   cout: 1'b0, ovf: 1'b0};
    vecs[6] = '{a: 8'h81,   b: 8'hFF,   res: 8'h80,   cout: 1'b1, ovf: 1'b0};

    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_a = 8'd0;
    bus.i_b = 8'd0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_done", 32'(bus.o_done), 32'd0);
    chk("rst_res",  32'(bus.o_res),  32'd0);
    chk("rst_cout", 32'(bus.o_cout), 32'd0);
    chk("rst_ovf",  32'(bus.o_ovf),  32'd0);
    tick();
    chk("idle_busy", 32'(bus.o_busy), 32'd0);

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].cout, vecs[i].ovf,
             $sformatf("vec%0d", i));
      tick();
    end

    // start during RUN is ignored and a/b changes after accept do not matter
    bus.i_a = 8'd10;
    bus.i_b = 8'd20;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    bus.i_a = 8'd3;
    tick();
    bus.i_b = 8'd77;
    tick();
    bus.i_a = 8'd99;
    bus.i_b = 8'd99;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      bus.i_a = 8'($urandom);
      bus.i_b = 8'($urandom);
      if (bus.o_done) begin
        dones++;
        chk("ign_res", 32'(bus.o_res), 32'd30);
      end
      tick();
    end
    chk("ign_done_count", 32'(dones), 32'd1);
    chk("ign_res_hold", 32'(bus.o_res), 32'd30);
    chk("ign_busy", 32'(bus.o_busy), 32'd0);
    prev_res = 8'd30;

    // start held through DONE: back-to-back operations
    bus.i_a = 8'd5;
    bus.i_b = 8'd6;
    bus.i_start = 1'b1;
    tick();
    bus.i_a = 8'd7;
    bus.i_b = 8'd8;
    n = 0;
    while (!bus.o_done && n < 20) begin
      tick();
      n++;
    end
    chk("b2b_lat1", 32'(n), 32'd8);
    chk("b2b_res1", 32'(bus.o_res), 32'd11);
    tick();
    bus.i_start = 1'b0;
    chk("b2b_busy_next", 32'(bus.o_busy), 32'd1);
    chk("b2b_done_low", 32'(bus.o_done), 32'd0);
    chk("b2b_res_hold", 32'(bus.o_res), 32'd11);
    n = 0;
    while (!bus.o_done && n < 20) begin
      tick();
      n++;
    end
    chk("b2b_lat2", 32'(n), 32'd8);
    chk("b2b_res2", 32'(bus.o_res), 32'd15);
    tick();
    chk("b2b_done_end", 32'(bus.o_done), 32'd0);
    prev_res = 8'd15;

    // reset on the 4th busy cycle discards the operation
    run_op(8'd124, 8'd1, 8'd125, 1'b0, 1'b0, "pre_rst");
    bus.i_a = 8'd50;
    bus.i_b = 8'd50;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_res_hold", 32'(bus.o_res), 32'd125);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", 32'(bus.o_busy), 32'd0);
    chk("mrst_done", 32'(bus.o_done), 32'd0);
    chk("mrst_res",  32'(bus.o_res),  32'd0);
    chk("mrst_cout", 32'(bus.o_cout), 32'd0);
    chk("mrst_ovf",  32'(bus.o_ovf),  32'd0);
    dones = 0;
    for (cyc = 0; cyc < 12; cyc++) begin
      if (bus.o_done || bus.o_busy) dones++;
      tick();
    end
    chk("mrst_quiet", 32'(dones), 32'd0);
    prev_res = 8'd0;
    run_op(8'd1, 8'd2, 8'd3, 1'b0, 1'b0, "post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
